// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: handshake and RAM-control bundle for the FIFO sequencer.
// master = upstream/consumer side (drives requests, sees flags and RAM drive),
// slave  = ram_fifo_ctrl itself.
interface ram_fifo_ctrl_if #(
  parameter int ADDR_W = 7
);
  // requests
  logic              flush_i;
  logic              push_i;
  logic              pop_i;
  // status
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic [ADDR_W:0]   count_o;
  logic              rd_valid_o;
  // RAM drive
  logic              ram_wr_en_o;
  logic [ADDR_W-1:0] ram_wr_addr_o;
  logic              ram_rd_en_o;
  logic [ADDR_W-1:0] ram_rd_addr_o;
  // sticky error flags
  logic              ovf_o;
  logic              udf_o;

  modport master (
    output flush_i, push_i, pop_i,
    input  full_o, empty_o, almost_full_o, count_o, rd_valid_o,
    input  ram_wr_en_o, ram_wr_addr_o, ram_rd_en_o, ram_rd_addr_o,
    input  ovf_o, udf_o
  );

  modport slave (
    input  flush_i, push_i, pop_i,
    output full_o, empty_o, almost_full_o, count_o, rd_valid_o,
    output ram_wr_en_o, ram_wr_addr_o, ram_rd_en_o, ram_rd_addr_o,
    output ovf_o, udf_o
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: control-only FIFO sequencer for a 2**ADDR_W x 8 simple
// dual-port RAM with 1-cycle read latency. Generates RAM enables/addresses,
// occupancy and flags; data never passes through this block.
// Optional macro RAM_FIFO_CTRL_ERR_STICKY_EN enables the sticky ovf_o/udf_o
// flags; without it both outputs are tied low.
module ram_fifo_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int AF_THRESH = 120
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ram_fifo_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] AF_TH = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            rd_valid_q, rd_valid_d;

  logic            full, empty;
  logic [ADDR_W:0] count;
  logic            push_ok, pop_ok;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  // Push on full is dropped even with a concurrent pop, so the RAM never sees
  // a read and write to the same address; pop on empty never falls through.
  assign push_ok = bus.push_i & ~full  & ~bus.flush_i;
  assign pop_ok  = bus.pop_i  & ~empty & ~bus.flush_i;

  assign bus.full_o        = full;
  assign bus.empty_o       = empty;
  assign bus.count_o       = count;
  assign bus.almost_full_o = (count >= AF_TH);
  assign bus.rd_valid_o    = rd_valid_q;

  assign bus.ram_wr_en_o   = push_ok;
  assign bus.ram_wr_addr_o = wr_ptr_q[ADDR_W-1:0];
  assign bus.ram_rd_en_o   = pop_ok;
  assign bus.ram_rd_addr_o = rd_ptr_q[ADDR_W-1:0];

  // Next-state: flush clears everything, otherwise advance on accepted ops.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = pop_ok;
    if (bus.flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      rd_valid_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
    end
  end

  // Pointer and read-valid registers; reset drops any in-flight read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef RAM_FIFO_CTRL_ERR_STICKY_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Error flags latch a dropped push/pop and hold until flush or reset.
  always_comb begin
    ovf_d = ovf_q | (bus.push_i & full  & ~bus.flush_i);
    udf_d = udf_q | (bus.pop_i  & empty & ~bus.flush_i);
    if (bus.flush_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  // Sticky error flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.ovf_o = ovf_q;
  assign bus.udf_o = udf_q;
`else
  assign bus.ovf_o = 1'b0;
  assign bus.udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: randomized scoreboard bench. A queue-based FIFO model
// predicts flags/addresses; popped entries go to an expected-data queue that
// a separate monitor drains whenever rd_valid_o is seen, comparing RAM data.
module tb_ram_fifo_ctrl;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int AF     = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  ram_fifo_ctrl #(.ADDR_W(ADDR_W), .AF_THRESH(AF)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // behavioural 128x8 simple dual-port RAM, 1-cycle read latency
  logic [7:0] mem [DEPTH];
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  always @(posedge clk) begin
    if (bus.ram_wr_en_o) mem[bus.ram_wr_addr_o] <= wr_data;
    if (bus.ram_rd_en_o) rd_data <= mem[bus.ram_rd_addr_o];
  end

  int tests = 0;
  int fails = 0;

  // reference model
  logic [7:0] q[$];
  logic [7:0] expq[$];
  int  wcnt = 0;
  int  rcnt = 0;
  bit  m_ovf = 0;
  bit  m_udf = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    expq.delete();
    wcnt = 0; rcnt = 0;
    m_ovf = 0; m_udf = 0;
  endtask

  function automatic int err_exp(input bit f);
`ifdef RAM_FIFO_CTRL_ERR_STICKY_EN
    return int'(f);
`else
    return 0;
`endif
  endfunction

  task automatic check_regs(input int exp_rv);
    check("count",       int'(bus.count_o),       q.size());
    check("empty",       int'(bus.empty_o),       int'(q.size() == 0));
    check("full",        int'(bus.full_o),        int'(q.size() == DEPTH));
    check("almost_full", int'(bus.almost_full_o), int'(q.size() >= AF));
    check("rd_valid",    int'(bus.rd_valid_o),    exp_rv);
    check("ovf",         int'(bus.ovf_o),         err_exp(m_ovf));
    check("udf",         int'(bus.udf_o),         err_exp(m_udf));
  endtask

  // One clock of stimulus: drive at negedge, check combinational RAM drive,
  // update the model at the edge, then check registered outputs.
  task automatic step(input bit push, input bit pop, input bit flush, input logic [7:0] d);
    bit pok, qok;
    @(negedge clk);
    bus.push_i = push; bus.pop_i = pop; bus.flush_i = flush; wr_data = d;
    pok = push && (q.size() < DEPTH) && !flush;
    qok = pop  && (q.size() > 0)     && !flush;
    #1;
    check("ram_wr_en",   int'(bus.ram_wr_en_o),   int'(pok));
    check("ram_rd_en",   int'(bus.ram_rd_en_o),   int'(qok));
    check("ram_wr_addr", int'(bus.ram_wr_addr_o), wcnt % DEPTH);
    check("ram_rd_addr", int'(bus.ram_rd_addr_o), rcnt % DEPTH);
    @(posedge clk);
    if (flush) begin
      model_clear();
    end else begin
      if (push && q.size() == DEPTH) m_ovf = 1;
      if (pop  && q.size() == 0)     m_udf = 1;
      if (qok) begin expq.push_back(q.pop_front()); rcnt++; end
      if (pok) begin q.push_back(d); wcnt++; end
    end
    #1;
    check_regs(int'(qok));
  endtask

  // Reset pulse placed mid-cycle; outputs must clear without a clock edge.
  task automatic reset_pulse();
    bus.push_i = 0; bus.pop_i = 0; bus.flush_i = 0;
    #1 rst = 1'b1;
    #1;
    model_clear();
    check_regs(0);
    check("rst_wr_en", int'(bus.ram_wr_en_o), 0);
    check("rst_rd_en", int'(bus.ram_rd_en_o), 0);
    #1 rst = 1'b0;
  endtask

  // monitor: every valid beat must match the next expected entry
  always @(negedge clk) begin
    if (!rst && bus.rd_valid_o) begin
      if (expq.size() == 0) begin
        check("rd_valid_unexpected", 1, 0);
      end else begin
        check("rd_data", int'(rd_data), int'(expq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.push_i = 0; bus.pop_i = 0; bus.flush_i = 0; wr_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_regs(0);
    check("reset_wr_en", int'(bus.ram_wr_en_o), 0);
    check("reset_rd_en", int'(bus.ram_rd_en_o), 0);
    rst = 1'b0;

    // directed: three pushes, three back-to-back pops
    step(1, 0, 0, 8'h45);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h11);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    // fill to full, then push+pop on full
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'($urandom));
    step(1, 1, 0, 8'hEE);

    // hold 64 entries while streaming across the address wrap
    while (q.size() > 64) step(0, 1, 0, 8'h00);
    for (int i = 0; i < 200; i++) step(1, 1, 0, 8'($urandom));

    // drain, then push+pop together while empty
    while (q.size() > 0) step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(1, 1, 0, 8'h5A);
    step(0, 0, 0, 8'h00);

    // random mix with occasional flush
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 9) < 6), bit'($urandom_range(0, 9) < 5),
           bit'($urandom_range(0, 49) == 0), 8'($urandom));

    // flush with a pop in flight
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 8'($urandom));
    step(1, 0, 0, 8'h00); // error flag exercise stays harmless here
    step(0, 1, 0, 8'h00);
    step(1, 1, 1, 8'h77);
    step(0, 0, 0, 8'h00);

    // reset mid-cycle with a pop in flight
    for (int i = 0; i < 10; i++) step(1, 0, 0, 8'($urandom));
    step(0, 1, 0, 8'h00);
    reset_pulse();
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'h3C);
    step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    check("expq_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
